conv1d_requant_engine: RTL and testbench



---
 rtl/conv1d_requant_engine.sv | 197 +++++++++++++++++++
 tb/tb_conv1d_requant_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_requant_engine.sv
// conv1d_requant_engine: int8 1-D convolution with LANES-wide int32 MAC, requantisation and cmd/rsp handshake
module conv1d_requant_engine #(
    parameter int MAX_LEN    = 1024,
    parameter int KERNEL_LEN = 8,
    parameter int LANES      = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd,
    input  logic [31:0] inp0,
    input  logic [31:0] inp1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] ret,
    output logic        busy
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int KW = $clog2(KERNEL_LEN);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

    logic [7:0] in_mem [MAX_LEN];
    logic [7:0] ker_mem [KERNEL_LEN];
    logic [7:0] out_mem [MAX_LEN];

    logic [1:0] state_q, state_d;
    logic [31:0] len_q, len_d, bias_q, bias_d, ret_q, ret_d, base_q, base_d, s1_base_q;
    logic signed [8:0] in_off_q, in_off_d;
    logic signed [7:0] out_off_q, out_off_d;
    logic [4:0] shift_q, shift_d;
    logic mode_q, mode_d, err_q, err_d, rsp_valid_q, rsp_valid_d, s1_v_q;
    logic signed [ACC_WIDTH-1:0] acc_d [LANES];
    logic signed [ACC_WIDTH-1:0] acc_q [LANES];
    logic [7:0] y [LANES];
    logic [LANES-1:0] lane_ok;
    logic signed [32:0] out_len;
    logic fire, start_bad, in_ok, ker_ok;
    logic [AW-1:0] in_idx;
    logic [KW-1:0] ker_idx;
    logic [31:0] in_word, ker_word, out_word;

    assign busy      = state_q != S_IDLE;
    assign cmd_ready = ~busy & ~rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign ret       = ret_q;
    assign fire      = cmd_valid & cmd_ready;
    assign out_len   = mode_q ? $signed({1'b0, len_q}) - 33'(KERNEL_LEN - 1) : $signed({1'b0, len_q});
    assign start_bad = (len_q == 32'd0) || (len_q > 32'(MAX_LEN)) || (out_len < 33'sd1);
    assign in_ok     = inp0 < 32'(MAX_LEN / 4);
    assign ker_ok    = inp0 < 32'(KERNEL_LEN / 4);
    assign in_idx    = AW'(inp0 << 2);
    assign ker_idx   = KW'(inp0 << 2);

    // Byte 0 of a word sits in bits [31:24]
    always_comb begin
        in_word = '0;
        ker_word = '0;
        out_word = '0;
        for (int j = 0; j < 4; j++) begin
            in_word[31-8*j -: 8]  = in_mem[in_idx + AW'(j)];
            ker_word[31-8*j -: 8] = ker_mem[ker_idx + KW'(j)];
            out_word[31-8*j -: 8] = out_mem[in_idx + AW'(j)];
        end
    end

    always_comb begin
        state_d = state_q;
        len_d = len_q;
        bias_d = bias_q;
        in_off_d = in_off_q;
        out_off_d = out_off_q;
        shift_d = shift_q;
        mode_d = mode_q;
        err_d = err_q;
        base_d = base_q;
        ret_d = ret_q;
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        if (fire) begin
            rsp_valid_d = 1'b1;
            ret_d = '0;
            case (cmd)
                7'd0: err_d = 1'b0;
                7'd1: err_d = err_q | ~in_ok;
                7'd2: err_d = err_q | ~ker_ok;
                7'd3: begin ret_d = in_ok ? out_word : '0; err_d = err_q | ~in_ok; end
                7'd4: len_d = inp0;
                7'd5: begin
                    if (start_bad) begin
                        err_d = 1'b1;
                        ret_d = '1;
                    end else begin
                        rsp_valid_d = 1'b0;
                        state_d = S_RUN;
                        base_d = '0;
                    end
                end
                7'd6: begin ret_d = in_ok ? in_word : '0; err_d = err_q | ~in_ok; end
                7'd7: begin ret_d = ker_ok ? ker_word : '0; err_d = err_q | ~ker_ok; end
                7'd8: bias_d = inp0;
                7'd9: begin in_off_d = inp0[8:0]; out_off_d = inp1[7:0]; end
                7'd10: shift_d = inp0[4:0];
                7'd11: mode_d = inp0[0];
                7'd12: ret_d = {err_q, 15'b0, out_len[15:0]};
                default: ;
            endcase
        end
        if (state_q == S_RUN) begin
            base_d = base_q + 32'(LANES);
            state_d = ($signed({1'b0, base_q}) + 33'(LANES) >= out_len) ? S_DRAIN : S_RUN;
        end
        if (state_q == S_DRAIN) begin
            state_d = S_IDLE;
            rsp_valid_d = 1'b1;
            ret_d = out_len[31:0];
        end
    end

    // Stage 1: taps outside [0,len) are zero padding and skip in_off
    always_comb begin
        int idx;
        logic signed [9:0] xv;
        logic signed [17:0] pr;
        idx = 0;
        xv = '0;
        pr = '0;
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = ACC_WIDTH'($signed(bias_q));
            for (int k = 0; k < KERNEL_LEN; k++) begin
                idx = int'(base_q) + l + k - (mode_q ? 0 : KERNEL_LEN / 2);
                xv = 10'($signed(in_mem[idx[AW-1:0]])) + 10'(in_off_q);
                pr = xv * $signed(ker_mem[k]);
                if (idx >= 0 && idx < int'(len_q))
                    acc_d[l] = acc_d[l] + ACC_WIDTH'(pr);
            end
        end
    end

    // Stage 2: round-half-up shift, output offset, int8 clamp
    always_comb begin
        logic signed [ACC_WIDTH-1:0] sh, rr, t;
        sh = '0;
        rr = '0;
        t = '0;
        for (int l = 0; l < LANES; l++) begin
            sh = acc_q[l] + ((shift_q == 5'd0) ? ACC_WIDTH'(0) : ACC_WIDTH'(1) << (shift_q - 5'd1));
            rr = sh >>> shift_q;
            t = rr + ACC_WIDTH'(out_off_q);
            y[l] = (t > ACC_WIDTH'(127)) ? 8'h7F : (t < ACC_WIDTH'(-128)) ? 8'h80 : t[7:0];
            lane_ok[l] = $signed({1'b0, s1_base_q + 32'(l)}) < out_len;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
        if (fire && cmd == 7'd1 && in_ok)
            for (int j = 0; j < 4; j++) in_mem[in_idx + AW'(j)] <= inp1[31-8*j -: 8];
        if (fire && cmd == 7'd2 && ker_ok)
            for (int j = 0; j < 4; j++) ker_mem[ker_idx + KW'(j)] <= inp1[31-8*j -: 8];
        if (s1_v_q)
            for (int l = 0; l < LANES; l++)
                if (lane_ok[l]) out_mem[AW'(s1_base_q + 32'(l))] <= y[l];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q <= '0;
            bias_q <= '0;
            in_off_q <= '0;
            out_off_q <= '0;
            shift_q <= '0;
            mode_q <= 1'b0;
            err_q <= 1'b0;
            base_q <= '0;
            ret_q <= '0;
            rsp_valid_q <= 1'b0;
            s1_v_q <= 1'b0;
            s1_base_q <= '0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            bias_q <= bias_d;
            in_off_q <= in_off_d;
            out_off_q <= out_off_d;
            shift_q <= shift_d;
            mode_q <= mode_d;
            err_q <= err_d;
            base_q <= base_d;
            ret_q <= ret_d;
            rsp_valid_q <= rsp_valid_d;
            s1_v_q <= state_q == S_RUN;
            s1_base_q <= base_q;
        end
    end
endmodule

// File: tb/tb_conv1d_requant_engine.sv
// tb_conv1d_requant_engine: randomized and directed checks against an arithmetic reference model
module tb_conv1d_requant_engine;
    localparam int ML = 1024, KL = 8, LN = 8;

    logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic cmd_ready, rsp_valid, busy;
    logic [6:0] cmd = '0;
    logic [31:0] inp0 = '0, inp1 = '0, ret;

    int nvec = 0, nerr = 0;
    int m_in [ML];
    int m_ker [KL];
    int m_out [ML];
    int m_len = 0, m_bias = 0, m_in_off = 0, m_out_off = 0, m_shift = 0, m_mode = 0;
    logic [7:0] got [ML];
    logic [31:0] r;
    int lat;

    always #5 clk = ~clk;

    conv1d_requant_engine #(.MAX_LEN(ML), .KERNEL_LEN(KL), .LANES(LN), .ACC_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .inp0(inp0), .inp1(inp1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .ret(ret), .busy(busy)
    );

    task automatic do_cmd(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
        cmd_valid = 1'b1; cmd = c; inp0 = a; inp1 = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) begin
            nvec++; nerr++;
            $display("FAIL rsp_timeout cmd=%0d got rsp_valid=0 want 1", c);
        end
        r = ret;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic set_len(input int v);   m_len = v;   do_cmd(7'd4, 32'(v), 0); endtask
    task automatic set_bias(input int v);  m_bias = v;  do_cmd(7'd8, 32'(v), 0); endtask
    task automatic set_shift(input int v); m_shift = v; do_cmd(7'd10, 32'(v), 0); endtask
    task automatic set_mode(input int v);  m_mode = v;  do_cmd(7'd11, 32'(v), 0); endtask
    task automatic set_off(input int i, input int o);
        m_in_off = i; m_out_off = o;
        do_cmd(7'd9, 32'(i), 32'(o));
    endtask

    task automatic load_in(input int n);
        for (int w = 0; w < (n + 3) / 4; w++)
            do_cmd(7'd1, 32'(w), {8'(m_in[4*w]), 8'(m_in[4*w+1]), 8'(m_in[4*w+2]), 8'(m_in[4*w+3])});
    endtask

    task automatic load_ker();
        for (int w = 0; w < KL / 4; w++)
            do_cmd(7'd2, 32'(w), {8'(m_ker[4*w]), 8'(m_ker[4*w+1]), 8'(m_ker[4*w+2]), 8'(m_ker[4*w+3])});
    endtask

    // Direct evaluation of the convolution/requantisation formula on plain ints
    function automatic int model_run();
        int ol = m_mode ? m_len - KL + 1 : m_len;
        int p = m_mode ? 0 : KL / 2;
        for (int o = 0; o < ol; o++) begin
            int acc = m_bias;
            for (int k = 0; k < KL; k++) begin
                int i = o + k - p;
                if (i >= 0 && i < m_len) acc += m_ker[k] * (m_in[i] + m_in_off);
            end
            if (m_shift > 0) acc = (acc + (1 << (m_shift - 1))) >>> m_shift;
            acc += m_out_off;
            m_out[o] = acc > 127 ? 127 : acc < -128 ? -128 : acc;
        end
        return ol;
    endfunction

    task automatic start_read(input int ol, output logic [31:0] sr, output int sl);
        do_cmd(7'd5, 0, 0);
        sr = r; sl = lat;
        for (int w = 0; w < (ol + 3) / 4; w++) begin
            do_cmd(7'd3, 32'(w), 0);
            for (int j = 0; j < 4; j++) got[4*w+j] = r[31-8*j -: 8];
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) m_in[i] = i;
        for (int k = 0; k < KL; k++) m_ker[k] = 2;
        load_in(8); load_ker();
        set_len(8); set_bias(1); set_off(0, 0); set_shift(0); set_mode(0);
    endtask

    task automatic test_reset();
        #1;
        nvec++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || ret !== 32'd0) begin
            nerr++; $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b ret=%h want 1 0 0 0", cmd_ready, rsp_valid, busy, ret);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        do_cmd(7'd12, 0, 0);
        nvec++; if (r !== 32'd0 || lat != 1) begin
            nerr++; $display("FAIL reset_status got ret=%h lat=%0d want 0 lat 1", r, lat);
        end
    endtask

    task automatic test_same_mode();
        logic [31:0] sr; int sl, ol;
        load_ramp();
        do_cmd(7'd6, 1, 0);
        nvec++; if (r !== 32'h04050607) begin nerr++; $display("FAIL rd_in got %h want 04050607", r); end
        do_cmd(7'd7, 0, 0);
        nvec++; if (r !== 32'h02020202) begin nerr++; $display("FAIL rd_ker got %h want 02020202", r); end
        ol = model_run();
        start_read(ol, sr, sl);
        nvec++; if (sr !== 32'd8 || sl != 3) begin nerr++; $display("FAIL same_start got ret=%0d lat=%0d want 8 lat 3", sr, sl); end
        nvec++; if (got[0] !== 8'd13 || got[4] !== 8'd57) begin
            nerr++; $display("FAIL same_spot got %0d,%0d want 13,57", got[0], got[4]);
        end
        for (int o = 0; o < ol; o++) begin
            nvec++; if (got[o] !== 8'(m_out[o])) begin nerr++; $display("FAIL same_out[%0d] got %h want %h", o, got[o], 8'(m_out[o])); end
        end
    endtask

    task automatic test_valid_mode();
        logic [31:0] sr; int sl;
        set_mode(1);
        start_read(1, sr, sl);
        nvec++; if (sr !== 32'd1 || sl != 3 || got[0] !== 8'd57) begin
            nerr++; $display("FAIL valid_basic got ret=%0d lat=%0d out0=%0d want 1 3 57", sr, sl, got[0]);
        end
        set_off(1, 0);
        start_read(1, sr, sl);
        nvec++; if (got[0] !== 8'd73) begin nerr++; $display("FAIL valid_in_off got %0d want 73", got[0]); end
        set_off(0, 0);
    endtask

    task automatic test_saturation();
        logic [31:0] sr; int sl;
        for (int i = 0; i < 8; i++) m_in[i] = 127;
        for (int k = 0; k < KL; k++) m_ker[k] = 127;
        load_in(8); load_ker(); set_mode(1);
        start_read(1, sr, sl);
        nvec++; if (got[0] !== 8'h7F) begin nerr++; $display("FAIL sat_pos got %h want 7f", got[0]); end
        for (int k = 0; k < KL; k++) m_ker[k] = -127;
        load_ker();
        start_read(1, sr, sl);
        nvec++; if (got[0] !== 8'h80) begin nerr++; $display("FAIL sat_neg got %h want 80", got[0]); end
    endtask

    task automatic test_rounding();
        logic [31:0] sr; int sl;
        load_ramp();
        set_shift(2);
        start_read(8, sr, sl);
        nvec++; if (got[0] !== 8'd3 || got[4] !== 8'd14) begin
            nerr++; $display("FAIL round_shift got %0d,%0d want 3,14", got[0], got[4]);
        end
        set_off(0, -5);
        start_read(8, sr, sl);
        nvec++; if (got[0] !== 8'hFE) begin nerr++; $display("FAIL round_out_off got %h want fe", got[0]); end
        set_off(0, 0); set_shift(0);
    endtask

    task automatic test_random();
        logic [31:0] sr; int sl, ol, n;
        for (int t = 0; t < 9; t++) begin
            set_mode(int'($urandom_range(0, 1)));
            n = (t == 8) ? ML : int'($urandom_range(m_mode ? KL : 1, 80));
            for (int i = 0; i < n; i++) m_in[i] = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < KL; k++) m_ker[k] = int'($urandom_range(0, 255)) - 128;
            load_in(n); load_ker(); set_len(n);
            set_bias((t % 4 == 3) ? int'($urandom) : int'($urandom_range(0, 2000000)) - 1000000);
            set_off(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 255)) - 128);
            set_shift(int'($urandom_range(0, 20)));
            ol = model_run();
            start_read(ol, sr, sl);
            nvec++; if (sr !== 32'(ol) || sl != (ol + LN - 1) / LN + 2) begin
                nerr++; $display("FAIL rand%0d_start got ret=%0d lat=%0d want %0d lat %0d", t, sr, sl, ol, (ol + LN - 1) / LN + 2);
            end
            for (int o = 0; o < ol; o++) begin
                nvec++; if (got[o] !== 8'(m_out[o])) begin nerr++; $display("FAIL rand%0d_out[%0d] got %h want %h", t, o, got[o], 8'(m_out[o])); end
            end
        end
    endtask

    task automatic test_errors();
        set_mode(0); set_len(0);
        do_cmd(7'd5, 0, 0);
        nvec++; if (r !== 32'hFFFF_FFFF || lat != 1) begin nerr++; $display("FAIL err_len0 got ret=%h lat=%0d want ffffffff lat 1", r, lat); end
        do_cmd(7'd12, 0, 0);
        nvec++; if (r !== 32'h8000_0000) begin nerr++; $display("FAIL err_status got %h want 80000000", r); end
        do_cmd(7'd0, 0, 0);
        do_cmd(7'd12, 0, 0);
        nvec++; if (r !== 32'd0) begin nerr++; $display("FAIL err_clear got %h want 0", r); end
        do_cmd(7'd1, ML / 4, 32'hDEADBEEF);
        do_cmd(7'd12, 0, 0);
        nvec++; if (r[31] !== 1'b1) begin nerr++; $display("FAIL err_wr_oob got bit31=%b want 1", r[31]); end
        do_cmd(7'd0, 0, 0);
        do_cmd(7'd3, ML / 4, 0);
        nvec++; if (r !== 32'd0) begin nerr++; $display("FAIL err_rd_oob got %h want 0", r); end
        do_cmd(7'd12, 0, 0);
        nvec++; if (r[31] !== 1'b1) begin nerr++; $display("FAIL err_rd_oob_flag got bit31=%b want 1", r[31]); end
        do_cmd(7'd0, 0, 0);
        set_len(ML + 1);
        do_cmd(7'd5, 0, 0);
        nvec++; if (r !== 32'hFFFF_FFFF || lat != 1) begin nerr++; $display("FAIL err_len_big got ret=%h lat=%0d want ffffffff lat 1", r, lat); end
        do_cmd(7'd0, 0, 0);
        set_len(KL - 1); set_mode(1);
        do_cmd(7'd5, 0, 0);
        nvec++; if (r !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL err_valid_short got %h want ffffffff", r); end
        do_cmd(7'd0, 0, 0);
        do_cmd(7'd13, 5, 5);
        nvec++; if (r !== 32'd0) begin nerr++; $display("FAIL bad_opcode got %h want 0", r); end
        set_mode(0);
    endtask

    task automatic test_handshake();
        logic [31:0] first;
        set_len(8);
        cmd_valid = 1'b1; cmd = 7'd12; inp0 = 0; inp1 = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        first = ret;
        for (int i = 0; i < 5; i++) begin
            nvec++; if (rsp_valid !== 1'b1 || ret !== 32'd8 || cmd_ready !== 1'b0) begin
                nerr++; $display("FAIL hold%0d got vld=%b ret=%h rdy=%b want 1 8 0", i, rsp_valid, ret, cmd_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        nvec++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || first !== 32'd8) begin
            nerr++; $display("FAIL hold_release got vld=%b rdy=%b first=%h want 0 1 8", rsp_valid, cmd_ready, first);
        end
    endtask

    task automatic test_reset_mid_run();
        set_len(ML); set_mode(0);
        cmd_valid = 1'b1; cmd = 7'd5; inp0 = 0; inp1 = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL run_busy got %b want 1", busy); end
        reset = 1'b1;
        #1;
        nvec++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL mid_reset got busy=%b rdy=%b vld=%b want 0 1 0", busy, cmd_ready, rsp_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_len = 0; m_bias = 0; m_in_off = 0; m_out_off = 0; m_shift = 0; m_mode = 0;
        do_cmd(7'd12, 0, 0);
        nvec++; if (r !== 32'd0) begin nerr++; $display("FAIL post_reset_status got %h want 0", r); end
    endtask

    initial begin
        test_reset();
        test_same_mode();
        test_valid_mode();
        test_saturation();
        test_rounding();
        test_random();
        test_errors();
        test_handshake();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
